// File: rtl/sdram_arbiter_pkg.sv
// Shared types and default timing for the two-port SDRAM slot arbiter.
// Owner encoding and the per-port request bundle are used by the top level.
package sdram_arb_pkg;

    localparam int DEF_SLOT_LEN     = 6;
    localparam int DEF_RD_CAPTURE   = 4;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [1:0]  ds;
        logic [15:0] din;
    } req_bundle_t;

endpackage

// File: rtl/sdram_slot_timer.sv
// Free-running access-slot counter plus the registered 8 MHz-equivalent slot sync.
// arb_edge marks the last cycle of a slot, whose closing edge is the arbitration edge.
module sdram_slot_timer #(
    parameter  int SLOT_LEN = 6,
    localparam int SLOT_W   = $clog2(SLOT_LEN)
) (
    input  logic              clk_64,
    input  logic              init,
    output logic [SLOT_W-1:0] slot,
    output logic              arb_edge,
    output logic              sdr_clk8
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOT_LEN - 1);
    localparam logic [SLOT_W-1:0] HALF_SLOT = SLOT_W'(SLOT_LEN / 2);

    logic [SLOT_W-1:0] r_slot;
    logic              r_clk8;
    logic [SLOT_W-1:0] w_slotNext;

    assign w_slotNext = (r_slot == LAST_SLOT) ? '0 : r_slot + SLOT_W'(1);

    // Sync is registered from the next slot value so its rising edge lands on slot cycle 0.
    always_ff @(posedge clk_64 or posedge init) begin
        if (init) begin
            r_slot <= '0;
            r_clk8 <= 1'b0;
        end else begin
            r_slot <= w_slotNext;
            r_clk8 <= (w_slotNext < HALF_SLOT);
        end
    end

    assign slot     = r_slot;
    assign arb_edge = (r_slot == LAST_SLOT);
    assign sdr_clk8 = r_clk8;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port slot arbiter in front of the SDRAM controller: port 0 has fixed priority,
// a saturating starvation counter forces port 1 through after STARVE_LIMIT lost slots.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int SLOT_LEN     = DEF_SLOT_LEN,
    parameter int RD_CAPTURE   = DEF_RD_CAPTURE,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk_64,
    input  logic        init,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [23:0] p0_addr,
    input  logic [1:0]  p0_ds,
    input  logic [15:0] p0_din,
    output logic        p0_ack,
    output logic [15:0] p0_dout,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [23:0] p1_addr,
    input  logic [1:0]  p1_ds,
    input  logic [15:0] p1_din,
    output logic        p1_ack,
    output logic [15:0] p1_dout,
    output logic        sdr_clk8,
    output logic        sdr_oe,
    output logic        sdr_we,
    output logic [23:0] sdr_addr,
    output logic [1:0]  sdr_ds,
    output logic [15:0] sdr_din,
    input  logic [15:0] sdr_dout
);

    localparam int                SLOT_W       = $clog2(SLOT_LEN);
    localparam logic [SLOT_W-1:0] CAPTURE_SLOT = SLOT_W'(RD_CAPTURE);
    localparam logic [2:0]        STARVE_MAX   = 3'(STARVE_LIMIT);

    logic [SLOT_W-1:0] w_slot;
    logic              w_arbEdge;
    logic              w_p1Forced;
    logic              w_capture;
    owner_t            w_nextOwner;
    req_bundle_t       w_p0Bundle;
    req_bundle_t       w_p1Bundle;
    req_bundle_t       w_winBundle;

    owner_t            r_owner;
    logic [2:0]        r_starve;
    logic              r_sdrOe;
    logic              r_sdrWe;
    logic [23:0]       r_sdrAddr;
    logic [1:0]        r_sdrDs;
    logic [15:0]       r_sdrDin;
    logic              r_p0Ack;
    logic              r_p1Ack;
    logic [15:0]       r_p0Dout;
    logic [15:0]       r_p1Dout;

    sdram_slot_timer #(
        .SLOT_LEN (SLOT_LEN)
    ) u_timer (
        .clk_64   (clk_64),
        .init     (init),
        .slot     (w_slot),
        .arb_edge (w_arbEdge),
        .sdr_clk8 (sdr_clk8)
    );

    assign w_p0Bundle = '{we: p0_we, addr: p0_addr, ds: p0_ds, din: p0_din};
    assign w_p1Bundle = '{we: p1_we, addr: p1_addr, ds: p1_ds, din: p1_din};
    assign w_p1Forced = p1_req && (r_starve == STARVE_MAX);
    assign w_capture  = (w_slot == CAPTURE_SLOT);

    always_comb begin
        w_nextOwner = OWN_NONE;
        if (p0_req && !w_p1Forced) begin
            w_nextOwner = OWN_P0;
        end else if (p1_req) begin
            w_nextOwner = OWN_P1;
        end
    end

    assign w_winBundle = (w_nextOwner == OWN_P1) ? w_p1Bundle : w_p0Bundle;

    // The winner's command is loaded on the arbitration edge so it is stable for the whole slot.
    always_ff @(posedge clk_64 or posedge init) begin
        if (init) begin
            r_owner   <= OWN_NONE;
            r_starve  <= '0;
            r_sdrOe   <= 1'b0;
            r_sdrWe   <= 1'b0;
            r_sdrAddr <= '0;
            r_sdrDs   <= '0;
            r_sdrDin  <= '0;
        end else if (w_arbEdge) begin
            r_owner <= w_nextOwner;
            r_sdrOe <= (w_nextOwner != OWN_NONE) && !w_winBundle.we;
            r_sdrWe <= (w_nextOwner != OWN_NONE) &&  w_winBundle.we;
            if (w_nextOwner != OWN_NONE) begin
                r_sdrAddr <= w_winBundle.addr;
                r_sdrDs   <= w_winBundle.ds;
                r_sdrDin  <= w_winBundle.din;
            end
            if ((w_nextOwner == OWN_P1) || !p1_req) begin
                r_starve <= '0;
            end else if ((w_nextOwner == OWN_P0) && (r_starve != 3'd7)) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end

    // Completion is decided in the capture cycle, so ack and read data appear one cycle later together.
    always_ff @(posedge clk_64 or posedge init) begin
        if (init) begin
            r_p0Ack  <= 1'b0;
            r_p1Ack  <= 1'b0;
            r_p0Dout <= '0;
            r_p1Dout <= '0;
        end else begin
            r_p0Ack <= w_capture && (r_owner == OWN_P0);
            r_p1Ack <= w_capture && (r_owner == OWN_P1);
            if (w_capture && r_sdrOe && (r_owner == OWN_P0)) begin
                r_p0Dout <= sdr_dout;
            end
            if (w_capture && r_sdrOe && (r_owner == OWN_P1)) begin
                r_p1Dout <= sdr_dout;
            end
        end
    end

    assign sdr_oe   = r_sdrOe;
    assign sdr_we   = r_sdrWe;
    assign sdr_addr = r_sdrAddr;
    assign sdr_ds   = r_sdrDs;
    assign sdr_din  = r_sdrDin;
    assign p0_ack   = r_p0Ack;
    assign p1_ack   = r_p1Ack;
    assign p0_dout  = r_p0Dout;
    assign p1_dout  = r_p1Dout;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot timing, single reads/writes, starvation rotation,
// mid-slot reset and back-to-back grants, with hand-computed expectations.
module tb_sdram_arbiter;

    localparam int SLOT_LEN = 6;

    logic        clk_64;
    logic        init;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [23:0] p0_addr, p1_addr;
    logic [1:0]  p0_ds, p1_ds;
    logic [15:0] p0_din, p1_din;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_dout, p1_dout;
    logic        sdr_clk8, sdr_oe, sdr_we;
    logic [23:0] sdr_addr;
    logic [1:0]  sdr_ds;
    logic [15:0] sdr_din;
    logic [15:0] sdr_dout;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    sdram_arbiter dut (
        .clk_64   (clk_64),
        .init     (init),
        .p0_req   (p0_req),
        .p0_we    (p0_we),
        .p0_addr  (p0_addr),
        .p0_ds    (p0_ds),
        .p0_din   (p0_din),
        .p0_ack   (p0_ack),
        .p0_dout  (p0_dout),
        .p1_req   (p1_req),
        .p1_we    (p1_we),
        .p1_addr  (p1_addr),
        .p1_ds    (p1_ds),
        .p1_din   (p1_din),
        .p1_ack   (p1_ack),
        .p1_dout  (p1_dout),
        .sdr_clk8 (sdr_clk8),
        .sdr_oe   (sdr_oe),
        .sdr_we   (sdr_we),
        .sdr_addr (sdr_addr),
        .sdr_ds   (sdr_ds),
        .sdr_din  (sdr_din),
        .sdr_dout (sdr_dout)
    );

    initial clk_64 = 1'b0;
    always #5 clk_64 = ~clk_64;

    // Independent slot-position reference: cycles elapsed since the last reset release.
    always @(posedge clk_64 or posedge init) begin
        if (init) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic goto_slot(input int s);
        for (int i = 0; i < 2 * SLOT_LEN; i++) begin
            @(negedge clk_64);
            if (cyc % SLOT_LEN == s) return;
        end
        vectors++;
        miscompares++;
        $display("[TB] FAIL goto_slot got %0d want %0d", cyc % SLOT_LEN, s);
    endtask

    task automatic do_reset();
        init = 1'b1;
        repeat (2) @(negedge clk_64);
        init = 1'b0;
    endtask

    task automatic test_reset();
        init = 1'b1;
        repeat (3) @(negedge clk_64);
        vectors++;
        if ({p0_ack, p1_ack, sdr_oe, sdr_we, sdr_clk8, sdr_addr, sdr_ds, sdr_din, p0_dout, p1_dout} !== 79'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %h want 0",
                     {p0_ack, p1_ack, sdr_oe, sdr_we, sdr_clk8, sdr_addr, sdr_ds, sdr_din, p0_dout, p1_dout});
        end
        init = 1'b0;
    endtask

    task automatic test_idle();
        logic expClk8;
        for (int k = 0; k < 2 * SLOT_LEN; k++) begin
            if (k > 0) @(negedge clk_64);
            expClk8 = (k != 0) && ((k % SLOT_LEN) < 3);
            vectors++;
            if ({sdr_oe, sdr_we, p0_ack, p1_ack} !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL idle_cmd k=%0d got %b want 0000", k, {sdr_oe, sdr_we, p0_ack, p1_ack});
            end
            vectors++;
            if (sdr_clk8 !== expClk8) begin
                miscompares++;
                $display("[TB] FAIL idle_clk8 k=%0d got %b want %b", k, sdr_clk8, expClk8);
            end
        end
    endtask

    task automatic test_p0_read();
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000123; p0_ds = 2'b11; sdr_dout = 16'hBEEF;
        for (int k = 0; k < SLOT_LEN; k++) begin
            if (k > 0) @(negedge clk_64);
            vectors++;
            if ({sdr_oe, p0_ack} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL p0rd_first_slot k=%0d got %b want 00", k, {sdr_oe, p0_ack});
            end
        end
        for (int k = 0; k < SLOT_LEN; k++) begin
            @(negedge clk_64);
            vectors++;
            if ({sdr_oe, sdr_we, sdr_addr} !== {1'b1, 1'b0, 24'h000123}) begin
                miscompares++;
                $display("[TB] FAIL p0rd_cmd k=%0d got %b%b %h want 10 000123", k, sdr_oe, sdr_we, sdr_addr);
            end
            vectors++;
            if (p0_ack !== (k == 5)) begin
                miscompares++;
                $display("[TB] FAIL p0rd_ack k=%0d got %b want %b", k, p0_ack, (k == 5));
            end
            if (k == 5) begin
                vectors++;
                if (p0_dout !== 16'hBEEF) begin
                    miscompares++;
                    $display("[TB] FAIL p0rd_dout got %h want BEEF", p0_dout);
                end
                p0_req = 1'b0;
            end
        end
        goto_slot(0);
        vectors++;
        if (sdr_oe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL p0rd_release got %b want 0", sdr_oe);
        end
    endtask

    task automatic test_p1_write();
        goto_slot(5);
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 24'h0ABCDE; p1_ds = 2'b01; p1_din = 16'h5A5A;
        sdr_dout = 16'h1111;
        for (int k = 0; k < SLOT_LEN; k++) begin
            @(negedge clk_64);
            vectors++;
            if ({sdr_oe, sdr_we, sdr_addr, sdr_ds, sdr_din} !== {1'b0, 1'b1, 24'h0ABCDE, 2'b01, 16'h5A5A}) begin
                miscompares++;
                $display("[TB] FAIL p1wr_cmd k=%0d got %b%b %h %b %h want 01 0ABCDE 01 5A5A",
                         k, sdr_oe, sdr_we, sdr_addr, sdr_ds, sdr_din);
            end
            vectors++;
            if ({p0_ack, p1_ack} !== {1'b0, (k == 5)}) begin
                miscompares++;
                $display("[TB] FAIL p1wr_ack k=%0d got %b want %b", k, {p0_ack, p1_ack}, {1'b0, (k == 5)});
            end
            if (k == 5) begin
                vectors++;
                if ({p1_dout, p0_dout} !== {16'h0000, 16'hBEEF}) begin
                    miscompares++;
                    $display("[TB] FAIL p1wr_dout got %h %h want 0000 BEEF", p1_dout, p0_dout);
                end
                p1_req = 1'b0;
            end
        end
        goto_slot(0);
        vectors++;
        if ({sdr_oe, sdr_we, sdr_addr, sdr_ds, sdr_din} !== {2'b00, 24'h0ABCDE, 2'b01, 16'h5A5A}) begin
            miscompares++;
            $display("[TB] FAIL idle_hold got %b%b %h %b %h want 00 0ABCDE 01 5A5A",
                     sdr_oe, sdr_we, sdr_addr, sdr_ds, sdr_din);
        end
    endtask

    task automatic test_starvation();
        logic        expP1;
        logic [23:0] expAddr;
        goto_slot(5);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000111; p0_ds = 2'b11;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 24'h000222; p1_ds = 2'b11;
        sdr_dout = 16'hC0DE;
        for (int s = 0; s < 10; s++) begin
            expP1   = (s % 5) == 4;
            expAddr = expP1 ? 24'h000222 : 24'h000111;
            goto_slot(0);
            vectors++;
            if ({sdr_oe, sdr_addr} !== {1'b1, expAddr}) begin
                miscompares++;
                $display("[TB] FAIL starve_owner slot=%0d got %b %h want 1 %h", s, sdr_oe, sdr_addr, expAddr);
            end
            goto_slot(5);
            vectors++;
            if ({p0_ack, p1_ack} !== {!expP1, expP1}) begin
                miscompares++;
                $display("[TB] FAIL starve_ack slot=%0d got %b want %b", s, {p0_ack, p1_ack}, {!expP1, expP1});
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        vectors++;
        if ({p0_dout, p1_dout} !== {16'hC0DE, 16'hC0DE}) begin
            miscompares++;
            $display("[TB] FAIL starve_dout got %h %h want C0DE C0DE", p0_dout, p1_dout);
        end
        goto_slot(0);
        vectors++;
        if (sdr_oe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL starve_release got %b want 0", sdr_oe);
        end
    endtask

    task automatic test_back_to_back();
        goto_slot(5);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000444; p0_ds = 2'b10;
        sdr_dout = 16'h4444;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < SLOT_LEN; k++) begin
                @(negedge clk_64);
                vectors++;
                if ({sdr_oe, sdr_addr, p0_ack, p1_ack} !== {1'b1, 24'h000444, (k == 5), 1'b0}) begin
                    miscompares++;
                    $display("[TB] FAIL b2b slot=%0d k=%0d got %b %h %b%b want 1 000444 %b0",
                             s, k, sdr_oe, sdr_addr, p0_ack, p1_ack, (k == 5));
                end
                if (s == 2 && k == 5) p0_req = 1'b0;
            end
        end
        goto_slot(0);
        vectors++;
        if ({sdr_oe, p0_dout} !== {1'b0, 16'h4444}) begin
            miscompares++;
            $display("[TB] FAIL b2b_release got %b %h want 0 4444", sdr_oe, p0_dout);
        end
    endtask

    task automatic test_init_midslot();
        goto_slot(5);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 24'h000333; p0_ds = 2'b11;
        sdr_dout = 16'h7777;
        goto_slot(0);
        vectors++;
        if ({sdr_oe, sdr_addr} !== {1'b1, 24'h000333}) begin
            miscompares++;
            $display("[TB] FAIL init_pre got %b %h want 1 000333", sdr_oe, sdr_addr);
        end
        goto_slot(2);
        init = 1'b1;
        #1;
        vectors++;
        if ({p0_ack, p1_ack, sdr_oe, sdr_we, sdr_clk8, sdr_addr, sdr_ds, sdr_din, p0_dout, p1_dout} !== 79'd0) begin
            miscompares++;
            $display("[TB] FAIL init_async got %h want 0",
                     {p0_ack, p1_ack, sdr_oe, sdr_we, sdr_clk8, sdr_addr, sdr_ds, sdr_din, p0_dout, p1_dout});
        end
        @(negedge clk_64);
        init = 1'b0;
        for (int k = 0; k < SLOT_LEN; k++) begin
            if (k > 0) @(negedge clk_64);
            vectors++;
            if ({sdr_oe, p0_ack} !== 2'b00) begin
                miscompares++;
                $display("[TB] FAIL init_first_slot k=%0d got %b want 00", k, {sdr_oe, p0_ack});
            end
        end
        for (int k = 0; k < SLOT_LEN; k++) begin
            @(negedge clk_64);
            vectors++;
            if ({sdr_oe, p0_ack} !== {1'b1, (k == 5)}) begin
                miscompares++;
                $display("[TB] FAIL init_regrant k=%0d got %b want %b", k, {sdr_oe, p0_ack}, {1'b1, (k == 5)});
            end
            if (k == 5) begin
                vectors++;
                if (p0_dout !== 16'h7777) begin
                    miscompares++;
                    $display("[TB] FAIL init_dout got %h want 7777", p0_dout);
                end
                p0_req = 1'b0;
            end
        end
    endtask

    initial begin
        init = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_ds = '0; p0_din = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_ds = '0; p1_din = '0;
        sdr_dout = '0;
        test_reset();
        test_idle();
        test_p0_read();
        test_p1_write();
        test_starvation();
        test_back_to_back();
        test_init_midslot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
